// File: rtl/store_write_buffer.sv
// ---------------------------------------------------------------------------
// store_write_buffer
//
// Purpose:
//    Store buffer sitting between the MEM-stage memory request and DataMemory.
//    Stores are queued in a small circular FIFO and written to DataMemory in
//    the background, each write holding the memory port for DRAIN_CYCLES
//    cycles. Loads take priority over draining. When the buffer cannot take
//    a store (or, without forwarding, cannot serve a load), Stall is raised
//    so the hazard logic holds the request.
//
// Optional feature (macro STORE_FORWARD_EN):
//    Defined     - loads search the buffer (newest matching entry wins) and a
//                  hit is answered from the buffer in the same cycle; misses
//                  go to DataMemory while draining pauses.
//    Not defined - no address comparators; any load while the buffer holds
//                  entries stalls until the buffer is empty, and draining
//                  carries on underneath the stalled load.
//
// Parameters:
//    DEPTH         number of buffered stores (power of 2, >= 2)
//    DRAIN_CYCLES  cycles DmMemWrite is held per drained entry (>= 1)
//
// Ports:
//    Clk          in   system clock, rising edge
//    Reset        in   synchronous active-high reset
//    Address      in   [31:0] CPU byte address (word aligned, [1:0] ignored)
//    WriteData    in   [31:0] CPU store data
//    MemWrite     in   CPU store request
//    MemRead      in   CPU load request
//    ReadData     out  [31:0] load result (0 when no load is served)
//    Stall        out  CPU must hold its request and retry
//    Empty        out  buffer holds no entries
//    DmAddress    out  [31:0] DataMemory address
//    DmWriteData  out  [31:0] DataMemory write data
//    DmMemWrite   out  DataMemory write enable
//    DmMemRead    out  DataMemory read enable
//    DmReadData   in   [31:0] combinational DataMemory read data
// ---------------------------------------------------------------------------
module store_write_buffer #(
   parameter int DEPTH        = 4,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic        MemRead,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        Empty,
   output logic [31:0] DmAddress,
   output logic [31:0] DmWriteData,
   output logic        DmMemWrite,
   output logic        DmMemRead,
   input  logic [31:0] DmReadData
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   typedef enum logic {
      IDLE,
      DRAIN
   } drainState_e;

   drainState_e   state_q, state_d;
   logic [PW:0]   count_q, count_d;
   logic [PW-1:0] rdPtr_q, rdPtr_d;
   logic [PW-1:0] wrPtr_q, wrPtr_d;
   logic [CW-1:0] drainCnt_q, drainCnt_d;

   // Word address and data of every slot; validity is implied by the
   // pointers and count, so the storage itself needs no reset.
   logic [29:0]   entryAddr_q [DEPTH];
   logic [31:0]   entryData_q [DEPTH];

   logic          isStore;
   logic          isLoad;
   logic          loadService;
   logic          loadStall;
   logic          headWrite;
   logic          retire;
   logic          storeAccept;

   // A simultaneous store+load is treated as a store; the load is dropped.
   assign isStore = MemWrite;
   assign isLoad  = MemRead & ~MemWrite;

`ifdef STORE_FORWARD_EN
   logic          fwdHit;
   logic [31:0]   fwdData;

   // Walk the valid entries from oldest to newest so the last match, which
   // is the youngest store to that word, is the one forwarded.
   always_comb begin
      fwdHit  = 1'b0;
      fwdData = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (((PW+1)'(i) < count_q) &&
             (entryAddr_q[rdPtr_q + PW'(i)] == Address[31:2])) begin
            fwdHit  = 1'b1;
            fwdData = entryData_q[rdPtr_q + PW'(i)];
         end
      end
   end

   assign loadService = isLoad;
   assign loadStall   = 1'b0;
`else
   // Without comparators a load can only be trusted once every older store
   // has reached DataMemory.
   assign loadService = isLoad & (count_q == '0);
   assign loadStall   = isLoad & (count_q != '0);
`endif

   // Drain FSM. The IDLE cycle that finds work already drives the head
   // write and counts as drain cycle 0, so entering DRAIN costs no bubble.
   // A load being served owns the memory port, freezing state and counter.
   always_comb begin
      state_d    = state_q;
      drainCnt_d = drainCnt_q;
      headWrite  = 1'b0;
      retire     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if ((count_q != '0) && !loadService) begin
               headWrite = 1'b1;
            end
         end
         DRAIN: begin
            if (!loadService) begin
               headWrite = 1'b1;
            end
         end
      endcase

      if (headWrite) begin
         if (drainCnt_q == CW'(DRAIN_CYCLES - 1)) begin
            retire     = 1'b1;
            drainCnt_d = '0;
            state_d    = (count_q == (PW+1)'(1)) ? IDLE : DRAIN;
         end else begin
            drainCnt_d = drainCnt_q + CW'(1);
            state_d    = DRAIN;
         end
      end
   end

   // A full buffer still takes a store when the head leaves on the same
   // edge; the new tail then reuses the slot the head just vacated.
   always_comb begin
      storeAccept = isStore & ((count_q != (PW+1)'(DEPTH)) | retire);

      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;

      if (storeAccept) begin
         wrPtr_d = wrPtr_q + PW'(1);
      end
      if (retire) begin
         rdPtr_d = rdPtr_q + PW'(1);
      end

      unique case ({storeAccept, retire})
         2'b10:   count_d = count_q + (PW+1)'(1);
         2'b01:   count_d = count_q - (PW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Control and pointer registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= IDLE;
         count_q    <= '0;
         rdPtr_q    <= '0;
         wrPtr_q    <= '0;
         drainCnt_q <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         rdPtr_q    <= rdPtr_d;
         wrPtr_q    <= wrPtr_d;
         drainCnt_q <= drainCnt_d;
      end
   end

   // Entry storage, written at the tail when a store is accepted.
   always_ff @(posedge Clk) begin
      if (storeAccept) begin
         entryAddr_q[wrPtr_q] <= Address[31:2];
         entryData_q[wrPtr_q] <= WriteData;
      end
   end

   // Memory-port and CPU-facing outputs. Everything is held quiet while
   // Reset is high so a drain interrupted by reset never completes a write.
   always_comb begin
      ReadData    = '0;
      DmAddress   = '0;
      DmWriteData = '0;
      DmMemWrite  = 1'b0;
      DmMemRead   = 1'b0;

      if (!Reset) begin
         if (headWrite) begin
            DmMemWrite  = 1'b1;
            DmAddress   = {entryAddr_q[rdPtr_q], 2'b00};
            DmWriteData = entryData_q[rdPtr_q];
         end
         if (loadService) begin
`ifdef STORE_FORWARD_EN
            if (fwdHit) begin
               ReadData = fwdData;
            end else begin
               DmMemRead = 1'b1;
               DmAddress = Address;
               ReadData  = DmReadData;
            end
`else
            DmMemRead = 1'b1;
            DmAddress = Address;
            ReadData  = DmReadData;
`endif
         end
      end
   end

   assign Stall = ~Reset & ((isStore & ~storeAccept) | loadStall);
   assign Empty = (count_q == '0);

endmodule

// File: tb/tb_store_write_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_write_buffer
//
// Directed testbench for store_write_buffer with a behavioural DataMemory
// (combinational read, write on the rising edge) that also logs every
// write cycle so drain order and write duration can be checked.
// Expectations differ for loads depending on STORE_FORWARD_EN.
// ---------------------------------------------------------------------------
module tb_store_write_buffer;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] ReadData;
   logic        Stall;
   logic        Empty;
   logic [31:0] DmAddress;
   logic [31:0] DmWriteData;
   logic        DmMemWrite;
   logic        DmMemRead;
   logic [31:0] DmReadData;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] mem [0:255];
   logic [31:0] logAddr [$];
   logic [31:0] logData [$];

   bit fillStallExp [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};

   store_write_buffer dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .Address     (Address),
      .WriteData   (WriteData),
      .MemWrite    (MemWrite),
      .MemRead     (MemRead),
      .ReadData    (ReadData),
      .Stall       (Stall),
      .Empty       (Empty),
      .DmAddress   (DmAddress),
      .DmWriteData (DmWriteData),
      .DmMemWrite  (DmMemWrite),
      .DmMemRead   (DmMemRead),
      .DmReadData  (DmReadData)
   );

   always #5 Clk = ~Clk;

   // Behavioural DataMemory with a log of every write-enabled cycle.
   assign DmReadData = mem[DmAddress[9:2]];

   always @(posedge Clk) begin
      if (DmMemWrite) begin
         mem[DmAddress[9:2]] <= DmWriteData;
         logAddr.push_back(DmAddress);
         logData.push_back(DmWriteData);
      end
   end

   task tick;
      @(posedge Clk);
      #1;
   endtask

   task idleInputs;
      MemWrite  = 1'b0;
      MemRead   = 1'b0;
      Address   = '0;
      WriteData = '0;
   endtask

   task waitEmpty(input int budget);
      int n;
      n = 0;
      while (!Empty && n < budget) begin
         tick;
         n++;
      end
      if (!Empty) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL wait_empty: Empty=%0b, required 1 within %0d cycles", Empty, budget);
      end
   endtask

   task test_reset;
      Reset = 1'b1;
      idleInputs;
      tick;
      tick;
      @(negedge Clk);
      vectors++; if (Empty !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_empty: got %0b, expected 1", Empty); end
      vectors++; if (Stall !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stall: got %0b, expected 0", Stall); end
      vectors++; if (DmMemWrite !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_dmwrite: got %0b, expected 0", DmMemWrite); end
      vectors++; if (DmMemRead !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_dmread: got %0b, expected 0", DmMemRead); end
      vectors++; if (ReadData !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_readdata: got %h, expected 0", ReadData); end
      tick;
      Reset = 1'b0;
      @(negedge Clk);
      vectors++; if (Empty !== 1'b1) begin miscompares++; $display("[TB] FAIL post_reset_empty: got %0b, expected 1", Empty); end
      vectors++; if (DmMemWrite !== 1'b0) begin miscompares++; $display("[TB] FAIL post_reset_dmwrite: got %0b, expected 0", DmMemWrite); end
      tick;
   endtask

   task test_single_store;
      MemWrite  = 1'b1;
      Address   = 32'h8;
      WriteData = 32'd18;
      @(negedge Clk);
      vectors++; if (Stall !== 1'b0) begin miscompares++; $display("[TB] FAIL single_stall: got %0b, expected 0", Stall); end
      vectors++; if (DmMemWrite !== 1'b0) begin miscompares++; $display("[TB] FAIL single_accept_dmwrite: got %0b, expected 0", DmMemWrite); end
      tick;
      idleInputs;
      for (int c = 0; c < 2; c++) begin
         @(negedge Clk);
         vectors++; if (DmMemWrite !== 1'b1 || DmAddress !== 32'h8 || DmWriteData !== 32'd18) begin
            miscompares++;
            $display("[TB] FAIL single_drain[%0d]: got we=%0b addr=%h data=%h, expected we=1 addr=8 data=12", c, DmMemWrite, DmAddress, DmWriteData);
         end
         tick;
      end
      @(negedge Clk);
      vectors++; if (DmMemWrite !== 1'b0) begin miscompares++; $display("[TB] FAIL single_drain_end: got %0b, expected 0", DmMemWrite); end
      vectors++; if (Empty !== 1'b1) begin miscompares++; $display("[TB] FAIL single_empty: got %0b, expected 1", Empty); end
      tick;
      MemRead = 1'b1;
      Address = 32'h8;
      @(negedge Clk);
      vectors++; if (ReadData !== 32'd18) begin miscompares++; $display("[TB] FAIL single_load_data: got %h, expected 12", ReadData); end
      vectors++; if (DmMemRead !== 1'b1) begin miscompares++; $display("[TB] FAIL single_load_dmread: got %0b, expected 1", DmMemRead); end
      tick;
      idleInputs;
   endtask

   task test_back_to_back;
      int start;
      int i;
      int idx;
      start = logAddr.size();
      i = 0;
      for (int k = 0; k < 9; k++) begin
         MemWrite  = 1'b1;
         MemRead   = 1'b0;
         Address   = 32'(i * 4);
         WriteData = 32'h100 + 32'(i);
         @(negedge Clk);
         vectors++; if (Stall !== fillStallExp[k]) begin miscompares++; $display("[TB] FAIL fill_stall[%0d]: got %0b, expected %0b", k, Stall, fillStallExp[k]); end
         tick;
         if (!fillStallExp[k]) i++;
      end
      idleInputs;
      waitEmpty(40);
      vectors++; if (logAddr.size() - start != 16) begin miscompares++; $display("[TB] FAIL fill_write_cycles: got %0d, expected 16", logAddr.size() - start); end
      for (int j = 0; j < 8; j++) begin
         for (int p = 0; p < 2; p++) begin
            idx = start + 2 * j + p;
            vectors++;
            if (idx >= logAddr.size() || logAddr[idx] !== 32'(j * 4) || logData[idx] !== 32'h100 + 32'(j)) begin
               miscompares++;
               $display("[TB] FAIL fill_order[%0d.%0d]: write log entry %0d of %0d wrong, expected addr=%h data=%h", j, p, idx, logAddr.size(), 32'(j * 4), 32'h100 + 32'(j));
            end
         end
      end
      for (int j = 0; j < 8; j++) begin
         vectors++; if (mem[j] !== 32'h100 + 32'(j)) begin miscompares++; $display("[TB] FAIL fill_mem[%0d]: got %h, expected %h", j, mem[j], 32'h100 + 32'(j)); end
      end
   endtask

   task test_forward;
`ifndef STORE_FORWARD_EN
      bit stallExp [4];
      stallExp = '{1, 1, 1, 0};
`endif
      MemWrite  = 1'b1;
      Address   = 32'h4;
      WriteData = 32'h11;
      tick;
      WriteData = 32'h22;
      tick;
      MemWrite = 1'b0;
      MemRead  = 1'b1;
      Address  = 32'h4;
`ifdef STORE_FORWARD_EN
      @(negedge Clk);
      vectors++; if (ReadData !== 32'h22) begin miscompares++; $display("[TB] FAIL fwd_data: got %h, expected 22", ReadData); end
      vectors++; if (DmMemRead !== 1'b0) begin miscompares++; $display("[TB] FAIL fwd_dmread: got %0b, expected 0", DmMemRead); end
      vectors++; if (DmMemWrite !== 1'b0) begin miscompares++; $display("[TB] FAIL fwd_dmwrite: got %0b, expected 0", DmMemWrite); end
      vectors++; if (Stall !== 1'b0) begin miscompares++; $display("[TB] FAIL fwd_stall: got %0b, expected 0", Stall); end
      tick;
`else
      for (int k = 0; k < 4; k++) begin
         @(negedge Clk);
         vectors++; if (Stall !== stallExp[k]) begin miscompares++; $display("[TB] FAIL nofwd_stall[%0d]: got %0b, expected %0b", k, Stall, stallExp[k]); end
         if (k == 3) begin
            vectors++; if (ReadData !== 32'h22) begin miscompares++; $display("[TB] FAIL nofwd_data: got %h, expected 22", ReadData); end
            vectors++; if (DmMemRead !== 1'b1) begin miscompares++; $display("[TB] FAIL nofwd_dmread: got %0b, expected 1", DmMemRead); end
            vectors++; if (Empty !== 1'b1) begin miscompares++; $display("[TB] FAIL nofwd_empty: got %0b, expected 1", Empty); end
         end else begin
            vectors++; if (ReadData !== 32'h0) begin miscompares++; $display("[TB] FAIL nofwd_stalled_data[%0d]: got %h, expected 0", k, ReadData); end
         end
         tick;
      end
`endif
      idleInputs;
      waitEmpty(20);
      vectors++; if (mem[1] !== 32'h22) begin miscompares++; $display("[TB] FAIL fwd_mem: got %h, expected 22", mem[1]); end
   endtask

   task test_load_during_drain;
      int start;
      MemWrite  = 1'b1;
      Address   = 32'h40;
      WriteData = 32'h55;
      tick;
      idleInputs;
      waitEmpty(10);
      start = logAddr.size();
      MemWrite  = 1'b1;
      Address   = 32'h20;
      WriteData = 32'h77;
      tick;
      idleInputs;
      @(negedge Clk);
      vectors++; if (DmMemWrite !== 1'b1 || DmAddress !== 32'h20) begin miscompares++; $display("[TB] FAIL ldrain_c0: got we=%0b addr=%h, expected we=1 addr=20", DmMemWrite, DmAddress); end
      tick;
      MemRead = 1'b1;
      Address = 32'h40;
      @(negedge Clk);
`ifdef STORE_FORWARD_EN
      vectors++; if (ReadData !== 32'h55) begin miscompares++; $display("[TB] FAIL ldrain_data: got %h, expected 55", ReadData); end
      vectors++; if (DmMemRead !== 1'b1 || DmMemWrite !== 1'b0) begin miscompares++; $display("[TB] FAIL ldrain_port: got rd=%0b we=%0b, expected rd=1 we=0", DmMemRead, DmMemWrite); end
      tick;
      idleInputs;
      @(negedge Clk);
      vectors++; if (DmMemWrite !== 1'b1 || DmAddress !== 32'h20) begin miscompares++; $display("[TB] FAIL ldrain_resume: got we=%0b addr=%h, expected we=1 addr=20", DmMemWrite, DmAddress); end
      tick;
      @(negedge Clk);
      vectors++; if (DmMemWrite !== 1'b0 || Empty !== 1'b1) begin miscompares++; $display("[TB] FAIL ldrain_done: got we=%0b empty=%0b, expected we=0 empty=1", DmMemWrite, Empty); end
      tick;
`else
      vectors++; if (Stall !== 1'b1 || ReadData !== 32'h0) begin miscompares++; $display("[TB] FAIL ldrain_stall: got stall=%0b data=%h, expected stall=1 data=0", Stall, ReadData); end
      vectors++; if (DmMemWrite !== 1'b1 || DmMemRead !== 1'b0) begin miscompares++; $display("[TB] FAIL ldrain_port: got we=%0b rd=%0b, expected we=1 rd=0", DmMemWrite, DmMemRead); end
      tick;
      @(negedge Clk);
      vectors++; if (ReadData !== 32'h55) begin miscompares++; $display("[TB] FAIL ldrain_data: got %h, expected 55", ReadData); end
      vectors++; if (Stall !== 1'b0 || Empty !== 1'b1) begin miscompares++; $display("[TB] FAIL ldrain_done: got stall=%0b empty=%0b, expected stall=0 empty=1", Stall, Empty); end
      tick;
      idleInputs;
`endif
      vectors++; if (logAddr.size() - start != 2) begin miscompares++; $display("[TB] FAIL ldrain_write_cycles: got %0d, expected 2", logAddr.size() - start); end
   endtask

   task test_illegal_combo;
      MemWrite  = 1'b1;
      MemRead   = 1'b1;
      Address   = 32'h80;
      WriteData = 32'h99;
      @(negedge Clk);
      vectors++; if (ReadData !== 32'h0 || DmMemRead !== 1'b0) begin miscompares++; $display("[TB] FAIL combo_load_ignored: got data=%h rd=%0b, expected data=0 rd=0", ReadData, DmMemRead); end
      vectors++; if (Stall !== 1'b0) begin miscompares++; $display("[TB] FAIL combo_stall: got %0b, expected 0", Stall); end
      tick;
      idleInputs;
      waitEmpty(10);
      vectors++; if (mem[32] !== 32'h99) begin miscompares++; $display("[TB] FAIL combo_mem: got %h, expected 99", mem[32]); end
   endtask

   task test_reset_mid_drain;
      int start;
      for (int k = 0; k < 4; k++) begin
         MemWrite  = 1'b1;
         Address   = 32'h60 + 32'(4 * k);
         WriteData = 32'hA0 + 32'(k);
         tick;
      end
      idleInputs;
      @(negedge Clk);
      vectors++; if (Empty !== 1'b0 || DmMemWrite !== 1'b1) begin miscompares++; $display("[TB] FAIL rmd_before: got empty=%0b we=%0b, expected empty=0 we=1", Empty, DmMemWrite); end
      Reset = 1'b1;
      start = logAddr.size();
      tick;
      Reset = 1'b0;
      @(negedge Clk);
      vectors++; if (Empty !== 1'b1) begin miscompares++; $display("[TB] FAIL rmd_empty: got %0b, expected 1", Empty); end
      vectors++; if (DmMemWrite !== 1'b0) begin miscompares++; $display("[TB] FAIL rmd_dmwrite: got %0b, expected 0", DmMemWrite); end
      vectors++; if (Stall !== 1'b0) begin miscompares++; $display("[TB] FAIL rmd_stall: got %0b, expected 0", Stall); end
      for (int c = 0; c < 10; c++) tick;
      vectors++; if (logAddr.size() != start) begin miscompares++; $display("[TB] FAIL rmd_no_writes: got %0d writes, expected 0", logAddr.size() - start); end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset;
      test_single_store;
      test_back_to_back;
      test_forward;
      test_load_during_drain;
      test_illegal_combo;
      test_reset_mid_drain;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
